// File: rtl/csa_stream_accumulator_if.sv
// ----------------------------------------------------------------------------
// csa_stream_accumulator_if
// Groups the beat handshake, the four operands and the result bus of
// csa_stream_accumulator.
//   slave  : the accumulator side (consumes beats, produces the result pair)
//   master : the producer/consumer side (drives beats, takes results)
// Signals:
//   in_valid_i / in_ready_o / in_last_i  beat handshake and end-of-accumulation
//   A_i, B_i, C_i, D_i                   XLEN-bit operands of a beat
//   out_valid_o / out_ready_i            result handshake
//   Sum_o, Carry_o                       redundant result pair
//   beats_o                              saturating beat count of the result
//   Result_o                             Sum_o + Carry_o, only with CSA_RESOLVE_EN
// Optional feature macro: CSA_RESOLVE_EN.
// ----------------------------------------------------------------------------
interface csa_stream_accumulator_if #(
  parameter int unsigned XLEN  = 49,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic             in_last_i;
  logic [XLEN-1:0]  A_i;
  logic [XLEN-1:0]  B_i;
  logic [XLEN-1:0]  C_i;
  logic [XLEN-1:0]  D_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  Sum_o;
  logic [XLEN-1:0]  Carry_o;
  logic [CNT_W-1:0] beats_o;
`ifdef CSA_RESOLVE_EN
  logic [XLEN-1:0]  Result_o;
`endif

  modport slave (
    input  in_valid_i, in_last_i, A_i, B_i, C_i, D_i, out_ready_i,
    output
`ifdef CSA_RESOLVE_EN
           Result_o,
`endif
           in_ready_o, out_valid_o, Sum_o, Carry_o, beats_o
  );

  modport master (
    output in_valid_i, in_last_i, A_i, B_i, C_i, D_i, out_ready_i,
    input
`ifdef CSA_RESOLVE_EN
           Result_o,
`endif
           in_ready_o, out_valid_o, Sum_o, Carry_o, beats_o
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// ----------------------------------------------------------------------------
// csa_stream_accumulator
// Multi-beat carry-save accumulator. Each accepted beat reduces
// {A, B, C, D, acc_sum, acc_carry} to a new sum/carry pair with two 4:2
// levels; no carry-propagate adder sits in the loop. When the beat flagged
// last is accepted, the redundant pair and the beat count are presented and
// held until the consumer takes them.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous reset, active-high
//   bus_io  csa_stream_accumulator_if.slave (beat handshake, operands, result)
// Optional feature macro: CSA_RESOLVE_EN adds Result_o and a registered
// carry-propagate add stage (one extra cycle of latency).
// ----------------------------------------------------------------------------
module csa_stream_accumulator #(
  parameter int unsigned XLEN  = 49,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  csa_stream_accumulator_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold, StResolve} state_e;

`ifdef CSA_RESOLVE_EN
  localparam state_e LastSt = StResolve;
`else
  localparam state_e LastSt = StHold;
`endif

  // Carry of a 3:2 compressor, weight-aligned; the bit leaving the MSB is dropped.
  function automatic logic [XLEN-1:0] csa_carry(input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y,
                                                input logic [XLEN-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  state_e           r_state, w_state_next;
  logic             w_in_ready, w_out_valid, w_accept, w_seed;
  logic [XLEN-1:0]  r_acc_sum, r_acc_carry, r_sum_out, r_carry_out;
  logic [XLEN-1:0]  w_acc_s_in, w_acc_c_in;
  logic [XLEN-1:0]  w_l1a_s, w_l1a_c, w_l1_s, w_l1_c;
  logic [XLEN-1:0]  w_l2a_s, w_l2a_c, w_s62, w_c62;
  logic [CNT_W-1:0] r_cnt, r_beats_out, w_cnt_next;

  assign w_accept = bus_io.in_valid_i && w_in_ready;
  // Outside ACCUM an accepted beat starts a new accumulation (IDLE, or HOLD
  // while the old result is being taken).
  assign w_seed     = (r_state != StAccum);
  assign w_acc_s_in = w_seed ? '0 : r_acc_sum;
  assign w_acc_c_in = w_seed ? '0 : r_acc_carry;

  // First 4:2 level: A, B, C, D.
  assign w_l1a_s = bus_io.A_i ^ bus_io.B_i ^ bus_io.C_i;
  assign w_l1a_c = csa_carry(bus_io.A_i, bus_io.B_i, bus_io.C_i);
  assign w_l1_s  = w_l1a_s ^ w_l1a_c ^ bus_io.D_i;
  assign w_l1_c  = csa_carry(w_l1a_s, w_l1a_c, bus_io.D_i);

  // Second 4:2 level: first-level pair plus the running accumulator pair.
  assign w_l2a_s = w_l1_s ^ w_l1_c ^ w_acc_s_in;
  assign w_l2a_c = csa_carry(w_l1_s, w_l1_c, w_acc_s_in);
  assign w_s62   = w_l2a_s ^ w_l2a_c ^ w_acc_c_in;
  assign w_c62   = csa_carry(w_l2a_s, w_l2a_c, w_acc_c_in);

  assign w_cnt_next = w_seed ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));

  // FSM: state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StAccum: begin
        if (w_accept) w_state_next = bus_io.in_last_i ? LastSt : StAccum;
      end
      StResolve: w_state_next = StHold;
      StHold: begin
        if (bus_io.out_ready_i) begin
          if (w_accept) w_state_next = bus_io.in_last_i ? LastSt : StAccum;
          else          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      StIdle, StAccum: w_in_ready = 1'b1;
      StHold: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus_io.out_ready_i;
      end
      default: ;
    endcase
  end

  // Accumulator and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc_sum   <= '0;
      r_acc_carry <= '0;
      r_cnt       <= '0;
      r_sum_out   <= '0;
      r_carry_out <= '0;
      r_beats_out <= '0;
    end else begin
      if (w_accept) begin
        r_acc_sum   <= w_s62;
        r_acc_carry <= w_c62;
        r_cnt       <= w_cnt_next;
      end
`ifdef CSA_RESOLVE_EN
      if (r_state == StResolve) begin
        r_sum_out   <= r_acc_sum;
        r_carry_out <= r_acc_carry;
        r_beats_out <= r_cnt;
      end
`else
      if (w_accept && bus_io.in_last_i) begin
        r_sum_out   <= w_s62;
        r_carry_out <= w_c62;
        r_beats_out <= w_cnt_next;
      end
`endif
    end
  end

`ifdef CSA_RESOLVE_EN
  logic [XLEN-1:0] r_result;

  // Final pair is resolved from the accumulator while in the intermediate state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_result <= '0;
    end else if (r_state == StResolve) begin
      r_result <= r_acc_sum + r_acc_carry;
    end
  end

  assign bus_io.Result_o = r_result;
`endif

  assign bus_io.in_ready_o  = w_in_ready;
  assign bus_io.out_valid_o = w_out_valid;
  assign bus_io.Sum_o       = r_sum_out;
  assign bus_io.Carry_o     = r_carry_out;
  assign bus_io.beats_o     = r_beats_out;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// ----------------------------------------------------------------------------
// tb_csa_stream_accumulator
// Self-checking bench for csa_stream_accumulator: a table of single-beat
// vectors, hand-written multi-cycle sequences, and a randomized phase scored
// against a plain-arithmetic transaction model. A second instance with
// CNT_W = 2 exercises beat-count saturation. Honours CSA_RESOLVE_EN.
// ----------------------------------------------------------------------------
module tb_csa_stream_accumulator;
  localparam int unsigned XLEN  = 49;
  localparam int unsigned CNT_W = 8;
`ifdef CSA_RESOLVE_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif

  typedef logic [XLEN-1:0] word_t;
  typedef struct {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t s;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  csa_stream_accumulator_if #(.XLEN(XLEN), .CNT_W(2))     bus2 ();

  csa_stream_accumulator #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  csa_stream_accumulator #(.XLEN(XLEN), .CNT_W(2)) u_dut_sat (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus2)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t resolved();
    word_t r;
    r = bus.Sum_o + bus.Carry_o;
    return r;
  endfunction

  task automatic idle_in();
    bus.in_valid_i  = 1'b0;
    bus.in_last_i   = 1'b0;
    bus.A_i         = '0;
    bus.B_i         = '0;
    bus.C_i         = '0;
    bus.D_i         = '0;
    bus.out_ready_i = 1'b0;
  endtask

  // Offers one beat for one cycle; caller guarantees in_ready_o is high.
  task automatic beat(input word_t a, input word_t b, input word_t c, input word_t d,
                      input logic last);
    bus.in_valid_i = 1'b1;
    bus.in_last_i  = last;
    bus.A_i        = a;
    bus.B_i        = b;
    bus.C_i        = c;
    bus.D_i        = d;
    tick();
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic check_result(input string name, input word_t exp_s, input int unsigned exp_n);
    chk({name, "_valid"}, 64'(bus.out_valid_o), 64'd1);
    chk({name, "_sum"}, 64'(resolved()), 64'(exp_s));
    chk({name, "_beats"}, 64'(bus.beats_o), 64'(exp_n));
`ifdef CSA_RESOLVE_EN
    chk({name, "_result"}, 64'(bus.Result_o), 64'(exp_s));
`endif
  endtask

  task automatic pop(input string name);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk({name, "_popped"}, 64'(bus.out_valid_o), 64'd0);
  endtask

  vec_t tbl [5];

  initial begin
    bit    pend, accum;
    int unsigned age, m_cnt, p_cnt;
    word_t m_sum, p_sum;

    tbl[0] = '{49'd1, 49'd2, 49'd3, 49'd4, 49'd10};
    tbl[1] = '{49'h1_0000_0000_0000, 49'h1_0000_0000_0000, 49'h1_0000_0000_0000,
               49'h1_0000_0000_0000, 49'd0};
    tbl[2] = '{49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF,
               49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFC};
    tbl[3] = '{49'h0_AAAA_AAAA_AAAA, 49'h1_5555_5555_5555, 49'd0, 49'd0,
               49'h1_FFFF_FFFF_FFFF};
    tbl[4] = '{49'h1_0000_0000_0001, 49'h0_FFFF_FFFF_FFFF, 49'd1, 49'd2, 49'd3};

    idle_in();
    bus2.in_valid_i  = 1'b0;
    bus2.in_last_i   = 1'b0;
    bus2.A_i         = '0;
    bus2.B_i         = '0;
    bus2.C_i         = '0;
    bus2.D_i         = '0;
    bus2.out_ready_i = 1'b0;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst_sum", 64'(bus.Sum_o), 64'd0);
    chk("rst_carry", 64'(bus.Carry_o), 64'd0);
    chk("rst_beats", 64'(bus.beats_o), 64'd0);
`ifdef CSA_RESOLVE_EN
    chk("rst_result", 64'(bus.Result_o), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Single-beat table.
    for (int i = 0; i < 5; i++) begin
      beat(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, 1'b1);
`ifdef CSA_RESOLVE_EN
      chk("tbl_gap_valid", 64'(bus.out_valid_o), 64'd0);
      chk("tbl_gap_ready", 64'(bus.in_ready_o), 64'd0);
      tick();
`endif
      check_result($sformatf("tbl%0d", i), tbl[i].s, 1);
      pop("tbl");
    end

    // Three beats of 2^48: the MSB carries must fall off the top.
    for (int i = 0; i < 3; i++) begin
      beat(49'h1_0000_0000_0000, 49'h1_0000_0000_0000, 49'h1_0000_0000_0000,
           49'h1_0000_0000_0000, logic'(i == 2));
      if (i < 2) chk("msb_not_yet_valid", 64'(bus.out_valid_o), 64'd0);
    end
    repeat (Lat - 1) tick();
    check_result("msb", 49'd0, 3);
    pop("msb");

    // Bubbles then backpressure.
    beat(49'd5, 49'd5, 49'd5, 49'd5, 1'b0);
    repeat (3) tick();
    chk("bubble_no_valid", 64'(bus.out_valid_o), 64'd0);
    beat(49'd7, 49'd0, 49'd0, 49'd0, 1'b1);
    repeat (Lat - 1) tick();
    for (int i = 0; i < 4; i++) begin
      check_result("held", 49'd27, 2);
      bus.in_valid_i = 1'b1;
      bus.A_i        = 49'h1234;
      #1;
      chk("held_in_ready", 64'(bus.in_ready_o), 64'd0);
      tick();
    end
    bus.in_valid_i = 1'b0;
    bus.A_i        = '0;
    check_result("held_after", 49'd27, 2);
    pop("held");

    // Back-to-back: new single beat accepted in the cycle the result is taken.
    beat(49'd3, 49'd0, 49'd0, 49'd0, 1'b1);
    repeat (Lat - 1) tick();
    check_result("b2b_first", 49'd3, 1);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_last_i   = 1'b1;
    bus.A_i         = 49'd1;
    bus.B_i         = 49'd1;
    bus.C_i         = 49'd1;
    bus.D_i         = 49'd1;
    #1;
    chk("b2b_in_ready", 64'(bus.in_ready_o), 64'd1);
    tick();
    idle_in();
    repeat (Lat - 1) tick();
    check_result("b2b_second", 49'd4, 1);
    pop("b2b");

    // Beat-count saturation on the CNT_W = 2 instance.
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid_i = 1'b1;
      bus2.in_last_i  = logic'(i == 4);
      bus2.A_i        = 49'd1;
      tick();
    end
    bus2.in_valid_i = 1'b0;
    bus2.in_last_i  = 1'b0;
    bus2.A_i        = '0;
    repeat (Lat - 1) tick();
    begin
      word_t r2;
      r2 = bus2.Sum_o + bus2.Carry_o;
      chk("sat_valid", 64'(bus2.out_valid_o), 64'd1);
      chk("sat_sum", 64'(r2), 64'd5);
      chk("sat_beats", 64'(bus2.beats_o), 64'd3);
    end
    bus2.out_ready_i = 1'b1;
    tick();
    bus2.out_ready_i = 1'b0;
    chk("sat_popped", 64'(bus2.out_valid_o), 64'd0);

    // Reset in ACCUM discards the partial sum.
    beat(49'd100, 49'd100, 49'd0, 49'd0, 1'b0);
    beat(49'd100, 49'd0, 49'd0, 49'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_accum_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_accum_beats", 64'(bus.beats_o), 64'd0);
    beat(49'd9, 49'd0, 49'd0, 49'd0, 1'b1);
    repeat (Lat - 1) tick();
    check_result("after_rst", 49'd9, 1);

    // Reset in HOLD drops the result.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hold_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_hold_sum", 64'(bus.Sum_o), 64'd0);
    chk("rst_hold_beats", 64'(bus.beats_o), 64'd0);
    tick();

    // Randomized traffic against a transaction model: running sum/count of the
    // current accumulation and one outstanding result with its age in cycles.
    pend  = 1'b0;
    accum = 1'b0;
    age   = 0;
    m_cnt = 0;
    p_cnt = 0;
    m_sum = '0;
    p_sum = '0;
    for (int i = 0; i < 3000; i++) begin
      bit    ev, er, acc, popd, v, l, ordy;
      word_t a, b, c, d;
      ev = pend && (age >= Lat - 1);
      chk("rnd_valid", 64'(bus.out_valid_o), 64'(ev));
      if (ev) begin
        chk("rnd_sum", 64'(resolved()), 64'(p_sum));
        chk("rnd_beats", 64'(bus.beats_o), 64'(p_cnt));
`ifdef CSA_RESOLVE_EN
        chk("rnd_result", 64'(bus.Result_o), 64'(p_sum));
`endif
      end
      v    = ($urandom_range(0, 3) != 0);
      l    = ($urandom_range(0, 3) == 0);
      ordy = 1'($urandom_range(0, 1));
      a    = word_t'({$urandom(), $urandom()});
      b    = word_t'({$urandom(), $urandom()});
      c    = word_t'({$urandom(), $urandom()});
      d    = word_t'({$urandom(), $urandom()});
      bus.in_valid_i  = v;
      bus.in_last_i   = l;
      bus.A_i         = a;
      bus.B_i         = b;
      bus.C_i         = c;
      bus.D_i         = d;
      bus.out_ready_i = ordy;
      er = !pend || (ev && ordy);
      #1;
      chk("rnd_in_ready", 64'(bus.in_ready_o), 64'(er));
      acc  = v && er;
      popd = ev && ordy;
      if (pend && !popd) age++;
      if (popd) pend = 1'b0;
      if (acc) begin
        if (!accum) begin
          m_sum = a + b + c + d;
          m_cnt = 1;
        end else begin
          m_sum = m_sum + a + b + c + d;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        accum = 1'b1;
        if (l) begin
          pend  = 1'b1;
          age   = 0;
          p_sum = m_sum;
          p_cnt = m_cnt;
          accum = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    idle_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
